// File: rtl/mem_stage_sb.sv
// Memory stage with a post-commit store buffer.
// Stores retire into a DEPTH-entry FIFO and drain to the D-cache in the
// background. Loads that miss the buffer bypass queued stores. Loads that
// overlap a queued store drain the buffer first.
// Optional feature macro: MEM_SB_FWD_EN. When it is defined, a load whose bytes
// are fully covered by the youngest matching entry is forwarded from the buffer.
// When it is undefined, every address match stalls the load until the buffer
// has drained past it.
module mem_stage_sb #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_read,
    input  logic                     in_write,
    input  logic [31:0]              in_addr,
    input  logic [DATA_W-1:0]        in_wdata,
    input  logic [DATA_W/8-1:0]      in_mbe,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     in_ready,
    output logic                     dc_read,
    output logic                     dc_write,
    output logic [31:0]              dc_addr,
    output logic [DATA_W-1:0]        dc_wdata,
    output logic [DATA_W/8-1:0]      dc_mbe,
    input  logic [DATA_W-1:0]        dc_rdata,
    input  logic                     dc_resp,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_rdata,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_empty
);

    localparam int BE_W = DATA_W / 8;
    localparam int OFF  = $clog2(BE_W);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam logic [31:0]   ALIGN_MASK = ~((32'd1 << OFF) - 32'd1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_sb_addr [DEPTH];
    logic [DATA_W-1:0]   r_sb_data [DEPTH];
    logic [BE_W-1:0]     r_sb_mbe  [DEPTH];
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [CW-1:0]       r_count;
    logic [31:0]         r_ld_addr;
    logic                r_ld_flush;

    logic [31:0]         w_in_aligned;
    logic                w_is_nop;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_accept;
    logic                w_match;
    logic [PW-1:0]       w_match_idx;
    logic                w_fwd;
    logic [DATA_W-1:0]   w_load_data;

    assign w_in_aligned = in_addr & ALIGN_MASK;
    assign w_is_nop     = in_valid & ~in_read & ~in_write;
    assign w_is_load    = in_valid & in_read & ~in_write;
    assign w_is_store   = in_valid & in_write;
    assign w_full       = (r_count == CNT_FULL);
    assign w_empty      = (r_count == '0);
    assign w_push       = w_is_store & ~w_full;
    assign w_pop        = (r_state == ST_DRAIN) & dc_resp;
    assign w_accept     = in_valid & in_ready;
    assign sb_count     = r_count;
    assign sb_empty     = w_empty;

    // Find the youngest valid entry holding the load's word address.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_count && r_sb_addr[r_head + PW'(i)] == w_in_aligned) begin
                w_match     = 1'b1;
                w_match_idx = r_head + PW'(i);
            end
        end
    end

`ifdef MEM_SB_FWD_EN
    // Forward only when the youngest match supplies every requested byte.
    assign w_fwd       = w_is_load & w_match & ((in_mbe & ~r_sb_mbe[w_match_idx]) == '0);
    assign w_load_data = w_fwd ? r_sb_data[w_match_idx] : dc_rdata;
`else
    logic w_unused_nofwd;
    assign w_fwd          = 1'b0;
    assign w_load_data    = dc_rdata;
    assign w_unused_nofwd = ^{in_mbe, w_match_idx};
`endif

    // Accept handshake: stores need room, loads need forwarding or a live cache response.
    always_comb begin
        in_ready = 1'b0;
        if (w_is_nop) begin
            in_ready = 1'b1;
        end else if (w_is_store) begin
            in_ready = ~w_full;
        end else if (w_is_load) begin
            in_ready = w_fwd | ((r_state == ST_LOAD) & dc_resp & ~r_ld_flush);
        end
    end

    // Cache port next state; an eligible load wins over a drain, a drain is never aborted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_is_load & ~w_fwd & ~w_match) begin
                    w_state_nxt = ST_LOAD;
                end else if (~w_empty) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_LOAD:  if (dc_resp) w_state_nxt = ST_IDLE;
            ST_DRAIN: if (dc_resp) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Cache request outputs decoded from the registered state, so they stay constant until dc_resp.
    always_comb begin
        dc_read  = 1'b0;
        dc_write = 1'b0;
        dc_addr  = '0;
        dc_wdata = '0;
        dc_mbe   = '0;
        if (r_state == ST_LOAD) begin
            dc_read = 1'b1;
            dc_addr = r_ld_addr;
        end else if (r_state == ST_DRAIN) begin
            dc_write = 1'b1;
            dc_addr  = r_sb_addr[r_head];
            dc_wdata = r_sb_data[r_head];
            dc_mbe   = r_sb_mbe[r_head];
        end
    end

    // Store buffer payload; written at the tail on each accepted store.
    // NOTE: the payload array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_addr[r_tail] <= w_in_aligned;
            r_sb_data[r_tail] <= in_wdata;
            r_sb_mbe[r_tail]  <= in_mbe;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_ONE;
            if (w_pop)  r_head <= r_head + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Cache port state, latched load address, and flush tracking for an abandoned load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ld_addr  <= '0;
            r_ld_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_LOAD) begin
                r_ld_addr <= w_in_aligned;
            end
            if (r_state != ST_LOAD || dc_resp) begin
                r_ld_flush <= 1'b0;
            end else if (!in_valid) begin
                r_ld_flush <= 1'b1;
            end
        end
    end

    // Writeback register: one pulse per accepted instruction, load data or zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_rdata <= '0;
            out_tag   <= '0;
        end else begin
            out_valid <= w_accept;
            if (w_accept) begin
                out_tag   <= in_tag;
                out_rdata <= w_is_load ? w_load_data : '0;
            end
        end
    end

endmodule
